// File: rtl/tgl_serial_add_drv.sv
// Serial driver for a two-phase dual-rail full adder: one operand bit per token, carry fed back.
// Optional WAIT watchdog enabled by defining TGL_DRV_TIMEOUT_EN.
module tgl_serial_add_drv #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             err,
   output logic             fn_rst,
   output logic [1:0]       fn_a,
   output logic [1:0]       fn_b,
   output logic [1:0]       fn_c_in,
   input  logic [1:0]       fn_s,
   input  logic [1:0]       fn_c_out
);

   localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int HOLD_W = $clog2(SYNC_STAGES + 1) + 1;

   typedef enum logic [2:0] {RST_HOLD, IDLE, SEND, WAIT, DONE} state_t;

   state_t            state;
   logic [HOLD_W-1:0] hold_cnt;
   logic [WIDTH-1:0]  a_q, b_q, sum_q, sum_next;
   logic              carry;
   logic [IDX_W-1:0]  idx;
   logic [1:0]        ref_s, ref_c;
   logic              s_done, c_done, s_val, c_val;
   logic [1:0]        s_sync [SYNC_STAGES];
   logic [1:0]        c_sync [SYNC_STAGES];
   logic [1:0]        s_lvl, c_lvl, s_diff, c_diff;
   logic              s_hit, c_hit, s_bad, c_bad;
   logic              s_done_n, c_done_n, s_val_n, c_val_n;
   logic              tmo_hit;

   // Returning rails are asynchronous to clk; plain multi-flop synchronisers per rail.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            s_sync[i] <= '0;
            c_sync[i] <= '0;
         end
      end else begin
         s_sync[0] <= fn_s;
         c_sync[0] <= fn_c_out;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            s_sync[i] <= s_sync[i-1];
            c_sync[i] <= c_sync[i-1];
         end
      end
   end

   // A pair completes when exactly one rail moved away from its reference level.
   always_comb begin
      s_lvl    = s_sync[SYNC_STAGES-1];
      c_lvl    = c_sync[SYNC_STAGES-1];
      s_diff   = s_lvl ^ ref_s;
      c_diff   = c_lvl ^ ref_c;
      s_hit    = s_diff[0] ^ s_diff[1];
      c_hit    = c_diff[0] ^ c_diff[1];
      s_bad    = &s_diff;
      c_bad    = &c_diff;
      s_done_n = s_done | s_hit;
      c_done_n = c_done | c_hit;
      s_val_n  = s_done ? s_val : s_diff[1];
      c_val_n  = c_done ? c_val : c_diff[1];
      sum_next = sum_q;
      sum_next[idx] = s_val_n;
   end

`ifdef TGL_DRV_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_cnt;

   assign tmo_hit = (state == WAIT) && (tmo_cnt == TMO_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       tmo_cnt <= '0;
      else if (state == SEND)           tmo_cnt <= '0;
      else if (state == WAIT && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
   end
`else
   logic unused_timeout;
   assign tmo_hit        = 1'b0;
   assign unused_timeout = ^TIMEOUT;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RST_HOLD;
         hold_cnt  <= '0;
         fn_rst    <= 1'b1;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         err       <= 1'b0;
         fn_a      <= 2'b00;
         fn_b      <= 2'b00;
         fn_c_in   <= 2'b00;
         ref_s     <= 2'b00;
         ref_c     <= 2'b00;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         carry     <= 1'b0;
         idx       <= '0;
         s_done    <= 1'b0;
         c_done    <= 1'b0;
         s_val     <= 1'b0;
         c_val     <= 1'b0;
      end else begin
         case (state)
            RST_HOLD: begin
               // Long enough for the adder's 00 outputs to flush through the synchronisers.
               fn_rst <= 1'b1;
               if (hold_cnt == HOLD_W'(SYNC_STAGES)) begin
                  hold_cnt <= '0;
                  fn_rst   <= 1'b0;
                  in_ready <= 1'b1;
                  state    <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            IDLE: begin
               if (in_valid) begin
                  a_q      <= in_a;
                  b_q      <= in_b;
                  carry    <= in_cin;
                  idx      <= '0;
                  sum_q    <= '0;
                  s_done   <= 1'b0;
                  c_done   <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= SEND;
               end
            end
            SEND: begin
               fn_a    <= fn_a    ^ (a_q[idx] ? 2'b10 : 2'b01);
               fn_b    <= fn_b    ^ (b_q[idx] ? 2'b10 : 2'b01);
               fn_c_in <= fn_c_in ^ (carry    ? 2'b10 : 2'b01);
               state   <= WAIT;
            end
            WAIT: begin
               if (s_bad || c_bad) begin
                  err      <= 1'b1;
                  ref_s    <= s_lvl;
                  ref_c    <= c_lvl;
                  in_ready <= 1'b1;
                  state    <= IDLE;
               end else if (tmo_hit) begin
                  // Silent adder: re-reset it so both sides restart from 00 rails.
                  err      <= 1'b1;
                  fn_rst   <= 1'b1;
                  fn_a     <= 2'b00;
                  fn_b     <= 2'b00;
                  fn_c_in  <= 2'b00;
                  ref_s    <= 2'b00;
                  ref_c    <= 2'b00;
                  hold_cnt <= '0;
                  state    <= RST_HOLD;
               end else if (s_done_n && c_done_n) begin
                  sum_q  <= sum_next;
                  carry  <= c_val_n;
                  ref_s  <= s_lvl;
                  ref_c  <= c_lvl;
                  s_done <= 1'b0;
                  c_done <= 1'b0;
                  if (idx == IDX_W'(WIDTH - 1)) begin
                     out_sum   <= sum_next;
                     out_cout  <= c_val_n;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= SEND;
                  end
               end else begin
                  s_done <= s_done_n;
                  c_done <= c_done_n;
                  s_val  <= s_val_n;
                  c_val  <= c_val_n;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= RST_HOLD;
         endcase
      end
   end

endmodule

// File: doc/tgl_serial_add_drv.md
# tgl_serial_add_drv

Clocked driver that runs WIDTH-bit additions through a single two-phase (transition-signalled) dual-rail full adder one bit per token. It accepts parallel operands over a valid/ready handshake, encodes a/b/carry bits as rail transitions toward the adder, and synchronises and decodes the adder's s/c_out transitions. It feeds c_out back as the next c_in and returns the assembled sum over a second valid/ready handshake. It sits directly upstream and downstream of the toggle-based full adder, bridging the synchronous domain to it.

## Interface
- WIDTH, 8, operand/sum width in bits (≥1)
- SYNC_STAGES, 2, flip-flop stages on each returning rail (≥2)
- TIMEOUT, 255, WAIT-state watchdog limit in cycles (used only with TGL_DRV_TIMEOUT_EN)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operands valid
- in_ready  out  1  driver can accept operands
- in_a, in_b  in  WIDTH  operands
- in_cin  in  1  carry in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  sum
- out_cout  out  1  final carry
- err  out  1  sticky protocol/timeout error
- fn_rst  out  1  active-high reset to the adder
- fn_a, fn_b, fn_c_in  out  2  dual-rail transition-encoded adder inputs, rail[v] toggles for value v
- fn_s, fn_c_out  in  2  dual-rail transition-encoded adder outputs, asynchronous to clk

## Operation
- Encoding: one token per pair = exactly one rail toggles. Rail 0 toggling means 0; rail 1 toggling means 1.
- FSM states: RST_HOLD, IDLE, SEND, WAIT, DONE.
- RST_HOLD:
  - fn_rst=1.
  - Exits to IDLE after SYNC_STAGES+1 cycles with rst_n high.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_a, in_b; carry←in_cin; idx←0; clear per-pair done flags; go to SEND.
- SEND (one cycle):
  - Toggle fn_a[a[idx]], fn_b[b[idx]], fn_c_in[carry] simultaneously. All fn_* are registered outputs.
  - Go to WAIT.
- WAIT:
  - Compare synchronised fn_s and fn_c_out against stored reference levels ref_s and ref_c.
  - A pair is complete when exactly one of its rails differs from its reference. Latch that pair's value and done flag; pairs may complete in different cycles.
  - When both pairs are done: sum[idx]←s value; carry←c value; ref←synchronised levels.
  - If idx==WIDTH-1, go to DONE; otherwise idx+1 and go to SEND.
- Error in WAIT: both rails of a pair differing from reference → err←1 (sticky), discard the operation, go to IDLE.
- DONE:
  - out_valid=1; out_sum and out_cout are held stable; in_ready=0.
  - On out_ready: go to IDLE.
- Reset values:
  - in_ready=0, out_valid=0, out_sum=0, out_cout=0, err=0.
  - fn_a/fn_b/fn_c_in=2'b00, ref_s/ref_c=2'b00, all synchronisers 0.
  - fn_rst=1, state=RST_HOLD.
- Reset mid-operation: the operation is abandoned with no output. The adder is re-reset through fn_rst, and rail/reference levels return to 00 consistently on both sides.

## Timing
- Input handshake: acceptance in IDLE; SEND occurs in the cycle after acceptance.
- Per bit, with zero-delay adder: 1 SEND + SYNC_STAGES synchroniser + 1 capture = SYNC_STAGES+2 cycles. Adder delay adds whole cycles.
- Minimum latency from input handshake to out_valid: WIDTH×(SYNC_STAGES+2)+1 cycles. With defaults this is 33.
- out_valid rises the cycle after the last bit is captured. The output handshake completes on the edge where out_valid&out_ready; in_ready rises the next cycle.
- Token issue: no new token is sent until both output pairs of the previous bit have completed.

## Configuration
- TGL_DRV_TIMEOUT_EN defined:
  - A counter runs in WAIT and clears on each SEND.
  - On reaching TIMEOUT: err←1, operation discarded, FSM to RST_HOLD so the adder is re-reset and all rails return to 00.
- Not defined: no counter; WAIT is held indefinitely until the adder completes.

## Test plan
- Reset: hold rst_n low 5 cycles → all reset values above. After release, fn_rst stays 1 for 3 cycles (SYNC_STAGES=2) and in_ready rises the following cycle.
- a=0x5A, b=0x3C, cin=0 → out_sum=0x96, out_cout=0. Exactly 8 single-rail toggles on each fn pair; latency 33 cycles with a zero-delay adder model.
- Carry ripple:
  - a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Backpressure: hold out_ready low 10 cycles in DONE → out_valid, out_sum and out_cout stable; in_ready=0. The next operand is accepted the cycle after in_ready rises.
- Protocol error: adder model toggles both fn_s rails → err=1 sticky, no out_valid, FSM returns to IDLE. err clears only via rst_n.
- Timeout with macro: adder model is silent → err=1 after 255 WAIT cycles and fn_rst is reasserted. Without the macro, the FSM stays in WAIT. Assert rst_n mid-WAIT → clean restart and a correct next sum.
